// File: rtl/sdram_frame_reader.sv
`default_nettype none
// ============================================================================
// sdram_frame_reader : streams a frame from SDRAM into a show-ahead pixel FIFO
// Rev 1.0
// ============================================================================
module sdram_frame_reader #(
  parameter int ADDR_W       = 25,
  parameter int DATA_W       = 16,
  parameter int FRAME_PIXELS = 76800,
  parameter int FIFO_DEPTH   = 16,
  parameter int FILL_LEVEL   = 8
) (
  input  logic              in_clk,
  input  logic              in_reset,
  input  logic              start,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_wait,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              pix_ready,
  output logic              pix_valid,
  output logic [7:0]        pix_data,
  output logic              frame_start,
  output logic              underflow,
  output logic [1:0]        state
);
  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam int c_idx_w = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam logic [ADDR_W-1:0]  c_last_addr = ADDR_W'(FRAME_PIXELS - 1);
  localparam logic [ADDR_W-1:0]  c_addr_one  = ADDR_W'(1);
  localparam logic [c_idx_w-1:0] c_last_idx  = c_idx_w'(FRAME_PIXELS - 1);
  localparam logic [c_idx_w-1:0] c_idx_one   = c_idx_w'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_one   = c_ptr_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_fill      = c_cnt_w'(FILL_LEVEL);
  localparam logic [c_cnt_w:0]   c_depth     = (c_cnt_w + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t              r_state, w_next;
  logic [7:0]          r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]  r_wr_ptr, r_rd_ptr;
  logic [c_cnt_w-1:0]  r_count, r_outstanding;
  logic [ADDR_W-1:0]   r_addr;
  logic [c_idx_w-1:0]  r_pop_idx;
  logic                r_frame_start, r_underflow;
  logic                w_streaming, w_empty, w_accept, w_return, w_push, w_pop;
  logic                w_start_fill, w_flush;
  logic [c_cnt_w:0]    w_level;
  logic [DATA_W-9:0]   w_unused_data;

  assign w_streaming  = (r_state == ST_FILL) || (r_state == ST_RUN);
  assign w_empty      = (r_count == '0);
  // Credits cover both buffered pixels and reads still in flight
  assign w_level      = {1'b0, r_count} + {1'b0, r_outstanding};
  assign rd_req       = w_streaming && (w_level < c_depth);
  assign w_accept     = rd_req && !rd_wait;
  assign w_return     = rd_valid && (r_outstanding != '0);
  assign w_push       = w_return && w_streaming;
  assign w_pop        = (r_state == ST_RUN) && pix_ready && !w_empty;
  assign w_start_fill = (r_state == ST_IDLE) && start;
  assign w_flush      = (r_state == ST_DRAIN) && (r_outstanding == '0);
  assign w_unused_data = rd_data[DATA_W-1:8];

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_FILL;
      ST_FILL: begin
        if (!start) w_next = ST_DRAIN;
        else if (r_count >= c_fill) w_next = ST_RUN;
      end
      ST_RUN:   if (!start) w_next = ST_DRAIN;
      ST_DRAIN: if (r_outstanding == '0) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) r_state <= ST_IDLE;
    else           r_state <= w_next;
  end

  always_ff @(posedge in_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= rd_data[7:0];
  end

  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_addr        <= '0;
      r_pop_idx     <= '0;
      r_frame_start <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      r_frame_start <= w_pop && (r_pop_idx == '0);
      r_underflow   <= r_underflow || ((r_state == ST_RUN) && pix_ready && w_empty);

      case ({w_accept, w_return})
        2'b10:   r_outstanding <= r_outstanding + c_cnt_one;
        2'b01:   r_outstanding <= r_outstanding - c_cnt_one;
        default: r_outstanding <= r_outstanding;
      endcase

      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + c_cnt_one;
          2'b01:   r_count <= r_count - c_cnt_one;
          default: r_count <= r_count;
        endcase
      end

      if (w_start_fill)  r_addr <= '0;
      else if (w_accept) r_addr <= (r_addr == c_last_addr) ? '0 : r_addr + c_addr_one;

      if (w_start_fill) r_pop_idx <= '0;
      else if (w_pop)   r_pop_idx <= (r_pop_idx == c_last_idx) ? '0 : r_pop_idx + c_idx_one;
    end
  end

  assign rd_addr     = r_addr;
  assign pix_valid   = (r_state == ST_RUN) && !w_empty;
  assign pix_data    = w_empty ? 8'd0 : r_mem[r_rd_ptr];
  assign frame_start = r_frame_start;
  assign underflow   = r_underflow;
  assign state       = r_state;
endmodule
`default_nettype wire

// File: tb/tb_sdram_frame_reader.sv
`default_nettype none
// tb_sdram_frame_reader : random SDRAM latency/wait model with a pixel
// scoreboard; expected stream is frame[k mod FRAME_PIXELS] from each start.
module tb_sdram_frame_reader;
  localparam int ADDR_W = 25;
  localparam int DATA_W = 16;
  localparam int FP     = 20;
  localparam int DEPTH  = 16;
  localparam int FILL   = 8;

  logic              in_clk = 1'b0;
  logic              in_reset = 1'b0;
  logic              start = 1'b0;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_wait = 1'b0;
  logic              rd_valid = 1'b0;
  logic [DATA_W-1:0] rd_data = '0;
  logic              pix_ready = 1'b0;
  logic              pix_valid;
  logic [7:0]        pix_data;
  logic              frame_start;
  logic              underflow;
  logic [1:0]        state;

  sdram_frame_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FRAME_PIXELS(FP),
    .FIFO_DEPTH(DEPTH), .FILL_LEVEL(FILL)
  ) dut (
    .in_clk(in_clk), .in_reset(in_reset), .start(start),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_wait(rd_wait),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .pix_ready(pix_ready), .pix_valid(pix_valid), .pix_data(pix_data),
    .frame_start(frame_start), .underflow(underflow), .state(state)
  );

  always #5 in_clk = ~in_clk;

  typedef struct { int due; logic [7:0] data; } ret_t;
  ret_t       ret_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] frame [FP];
  ret_t       new_ret;

  int checks = 0, failures = 0;
  int cyc = 0, last_due = 0, model_out = 0, accepts = 0, pops = 0;
  int exp_fill = 0, pop_idx = 0, exp_addr = 0;
  int ready_mode = 0, wait_mode = 0, lat_lo = 3, lat_hi = 3;
  logic fs_pend = 1'b0, prev_hold = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // SDRAM model and input driver: in-order returns after a random latency
  always @(negedge in_clk) begin
    cyc++;
    while (exp_q.size() < FP) begin
      exp_q.push_back(frame[exp_fill % FP]);
      exp_fill++;
    end
    if (!in_reset) begin
      rd_valid = 1'b0; rd_wait = 1'b0; pix_ready = 1'b0;
      ret_q.delete(); model_out = 0;
    end else begin
      if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
        rd_valid = 1'b1;
        rd_data  = {8'($urandom), ret_q[0].data};
        void'(ret_q.pop_front());
        model_out--;
      end else begin
        rd_valid = 1'b0;
        rd_data  = 16'($urandom);
      end
      rd_wait   = (wait_mode == 2) || (wait_mode == 1 && $urandom_range(0, 3) == 0);
      pix_ready = (ready_mode == 1) || (ready_mode == 2 && $urandom_range(0, 9) < 6);
      if (rd_req && !rd_wait) begin
        check("rd_addr_accept", 32'(rd_addr), 32'(exp_addr));
        exp_addr    = (exp_addr + 1) % FP;
        new_ret.due = cyc + int'($urandom_range(lat_lo, lat_hi));
        if (new_ret.due <= last_due) new_ret.due = last_due + 1;
        last_due     = new_ret.due;
        new_ret.data = (rd_addr < FP) ? frame[int'(rd_addr)] : 8'hEE;
        ret_q.push_back(new_ret);
        model_out++;
        accepts++;
      end
    end
  end

  // Monitor: scoreboard pops, frame_start, credit bound, waitrequest hold
  always @(negedge in_clk) begin
    #1;
    if (!in_reset) begin
      fs_pend = 1'b0; prev_hold = 1'b0;
    end else begin
      check("frame_start", 32'(frame_start), 32'(fs_pend));
      fs_pend = 1'b0;
      if (prev_hold && state != 2'd3) begin
        check("hold_req", 32'(rd_req), 32'd1);
        check("hold_addr", 32'(rd_addr), 32'(prev_addr));
      end
      prev_hold = rd_req && rd_wait;
      prev_addr = rd_addr;
      if (pix_valid) check("valid_only_in_run", 32'(state), 32'd2);
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL scoreboard_empty: got pixel %0d expected none", pix_data);
        end else begin
          check("pix_data", 32'(pix_data), 32'(exp_q.pop_front()));
        end
        if (pop_idx == 0) fs_pend = 1'b1;
        pop_idx = (pop_idx + 1) % FP;
        pops++;
      end
      check("credit_bound", 32'((accepts - pops) <= DEPTH), 32'd1);
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_rd_req"}, 32'(rd_req), 32'd0);
    check({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    check({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
    check({tag, "_pix_data"}, 32'(pix_data), 32'd0);
    check({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    check({tag, "_underflow"}, 32'(underflow), 32'd0);
  endtask

  initial begin
    int n;
    logic [7:0] key;
    logic [ADDR_W-1:0] held;
    key = 8'($urandom);
    for (int k = 0; k < FP; k++) frame[k] = 8'(k) ^ key;

    repeat (3) @(negedge in_clk);
    #2 check_reset_values("reset");

    // Basic stream, fixed latency 3, no waits
    @(negedge in_clk);
    in_reset = 1'b1; start = 1'b1; ready_mode = 1;
    n = 0;
    do begin @(negedge in_clk); #2; n++; end while (!pix_valid && n < 40);
    check("fill_latency_ok", 32'(n <= FILL + 3 + 2), 32'd1);
    n = 0;
    while (pops < 45 && n < 200) begin @(negedge in_clk); n++; end
    #2 check("basic_pops", 32'(pops >= 45), 32'd1);
    check("basic_underflow", 32'(underflow), 32'd0);

    // Backpressure
    ready_mode = 0;
    repeat (100) @(negedge in_clk);
    #2 check("bp_rd_req_low", 32'(rd_req), 32'd0);
    check("bp_pix_valid", 32'(pix_valid), 32'd1);
    ready_mode = 1;
    repeat (40) @(negedge in_clk);
    #2 check("bp_underflow", 32'(underflow), 32'd0);

    // Randomized waits, latency and consumer
    ready_mode = 2; wait_mode = 1; lat_lo = 2; lat_hi = 5;
    repeat (300) @(negedge in_clk);

    // Explicit 5-cycle waitrequest
    #2 ready_mode = 1; wait_mode = 0; lat_lo = 3; lat_hi = 3;
    repeat (20) @(negedge in_clk);
    n = 0;
    do begin @(negedge in_clk); #2; n++; end while (!rd_req && n < 50);
    check("wait_req_seen", 32'(rd_req), 32'd1);
    wait_mode = 2;
    @(negedge in_clk); #2 held = rd_addr;
    repeat (4) @(negedge in_clk);
    #2 check("wait_addr_held", 32'(rd_addr), 32'(held));
    check("wait_req_held", 32'(rd_req), 32'd1);
    wait_mode = 0;
    repeat (40) @(negedge in_clk);

    // Underflow on memory stall
    #2 wait_mode = 2;
    repeat (40) @(negedge in_clk);
    #2 check("uf_set", 32'(underflow), 32'd1);
    check("uf_valid_low", 32'(pix_valid), 32'd0);
    wait_mode = 0;
    repeat (40) @(negedge in_clk);
    #2 check("uf_sticky", 32'(underflow), 32'd1);
    check("uf_still_run", 32'(state), 32'd2);

    // Stop with 3 outstanding, restart during DRAIN
    n = 0;
    do begin @(negedge in_clk); #2; n++; end while (model_out != 3 && n < 50);
    check("outstanding_3", 32'(model_out), 32'd3);
    start = 1'b0;
    n = 0;
    do begin @(negedge in_clk); #2; n++; end while (state != 2'd3 && n < 10);
    check("drain_entered", 32'(state), 32'd3);
    check("drain_no_valid", 32'(pix_valid), 32'd0);
    start = 1'b1;
    exp_q.delete(); exp_fill = 0; exp_addr = 0;
    accepts = 0; pops = 0; pop_idx = 0;
    n = 0;
    do begin @(negedge in_clk); #2; n++; end while (state == 2'd3 && n < 20);
    check("drain_to_idle", 32'(state), 32'd0);
    check("idle_no_req", 32'(rd_req), 32'd0);
    n = 0;
    do begin @(negedge in_clk); #2; n++; end while (!pix_valid && n < 40);
    check("restart_valid", 32'(pix_valid), 32'd1);
    repeat (60) @(negedge in_clk);
    #2 check("restart_pops", 32'(pops >= 30), 32'd1);

    // Asynchronous reset mid-RUN
    in_reset = 1'b0;
    #1 check_reset_values("async_reset");
    start = 1'b0;
    repeat (3) @(negedge in_clk);
    #2 in_reset = 1'b1;
    #1 check("release_state", 32'(state), 32'd0);
    check("release_addr", 32'(rd_addr), 32'd0);
    repeat (2) @(negedge in_clk);
    #2 check("release_idle", 32'(state), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule
`default_nettype wire
